// File: rtl/result_reader.sv
// result_reader: once any decryption core reports success, latch the
// lowest-numbered winning core and stream its MESSAGE_LENGTH result bytes out
// over a valid/ready handshake, one byte per ADDR/WAIT/HOLD cycle triple.
module result_reader #(
   parameter int NUM_CORES          = 55,
   parameter int MESSAGE_LENGTH     = 32,
   parameter int MESSAGE_LOG_LENGTH = 5,
   parameter int RAM_WIDTH          = 8,
   localparam int CORE_W            = $clog2(NUM_CORES)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CORES-1:0]              success_bus,
   input  logic                              clear,
   output logic [MESSAGE_LOG_LENGTH-1:0]     a_rd_addr,
   output logic                              a_rd_en,
   input  logic [NUM_CORES*RAM_WIDTH-1:0]    a_q_bus,
   output logic [CORE_W-1:0]                 core_idx,
   output logic [RAM_WIDTH-1:0]              out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              out_last,
   output logic                              busy,
   output logic                              done
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam logic [MESSAGE_LOG_LENGTH-1:0] PTR_LAST = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);
   localparam logic [MESSAGE_LOG_LENGTH-1:0] PTR_ONE  = MESSAGE_LOG_LENGTH'(1);

   state_e                          state_q, state_d;
   logic [MESSAGE_LOG_LENGTH-1:0]   ptr_q, ptr_d;
   logic [CORE_W-1:0]               core_idx_q, core_idx_d;
   logic [RAM_WIDTH-1:0]            out_data_q, out_data_d;

   logic [CORE_W-1:0]               win_idx_s;
   logic [RAM_WIDTH-1:0]            rd_byte_s;
   logic                            ptr_last_s;
   logic                            busy_s;

   // Priority encoder: lowest set success flag wins (scan high to low so the lowest index is written last).
   always_comb begin
      win_idx_s = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         win_idx_s = success_bus[i] ? CORE_W'(i) : win_idx_s;
      end
   end

   assign rd_byte_s  = a_q_bus[int'(core_idx_q) * RAM_WIDTH +: RAM_WIDTH];
   assign ptr_last_s = (ptr_q == PTR_LAST);

   // Next-state logic; clear overrides everything and deliberately keeps core_idx and out_data.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      core_idx_d = core_idx_q;
      out_data_d = out_data_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (success_bus != '0) begin
                  core_idx_d = win_idx_s;
                  ptr_d      = '0;
                  state_d    = ST_ADDR;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ADDR: begin
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               // RAM data for ptr is valid now, one cycle after the address was presented.
               out_data_d = rd_byte_s;
               state_d    = ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  if (ptr_last_s) begin
                     state_d = ST_DONE;
                  end else begin
                     ptr_d   = ptr_q + PTR_ONE;
                     state_d = ST_ADDR;
                  end
               end else begin
                  state_d = ST_HOLD;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, pointer, winner and data registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         core_idx_q <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         core_idx_q <= core_idx_d;
         out_data_q <= out_data_d;
      end
   end

   // Moore decode of the state register; all outputs follow registered state only.
   always_comb begin
      busy_s    = (state_q == ST_ADDR) || (state_q == ST_WAIT) || (state_q == ST_HOLD);
      busy      = busy_s;
      a_rd_en   = busy_s;
      a_rd_addr = busy_s ? ptr_q : '0;
      out_valid = (state_q == ST_HOLD);
      out_last  = (state_q == ST_HOLD) && ptr_last_s;
      done      = (state_q == ST_DONE);
      core_idx  = core_idx_q;
      out_data  = out_data_q;
   end

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: directed scenarios plus a randomized phase, all
// checked every cycle against a transaction-level model of the byte stream.
module tb_result_reader;
   localparam int NC = 55;
   localparam int ML = 32;
   localparam int LW = 5;
   localparam int RW = 8;
   localparam int CW = $clog2(NC);

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NC-1:0]     success_bus = '0;
   logic              clear = 1'b0;
   logic [LW-1:0]     a_rd_addr;
   logic              a_rd_en;
   logic [NC*RW-1:0]  a_q_bus = '0;
   logic [CW-1:0]     core_idx;
   logic [RW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              out_last;
   logic              busy;
   logic              done;

   result_reader dut (
      .clk(clk), .reset(reset), .success_bus(success_bus), .clear(clear),
      .a_rd_addr(a_rd_addr), .a_rd_en(a_rd_en), .a_q_bus(a_q_bus),
      .core_idx(core_idx), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Result RAMs: registered address, data one cycle later.
   logic [RW-1:0] mem [NC][ML];
   always @(posedge clk) begin
      for (int c = 0; c < NC; c++) a_q_bus[c*RW +: RW] <= mem[c][a_rd_addr];
   end

   // Transaction-level model: streaming flag, winner, byte index, cycles spent on current byte.
   bit            m_active, m_done;
   int            m_core, m_byte, m_cnt;
   logic [RW-1:0] m_data;
   logic [RW-1:0] got_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   function automatic int lowest(input logic [NC-1:0] b);
      for (int i = 0; i < NC; i++) if (b[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_active = 0; m_done = 0; m_core = 0; m_byte = 0; m_cnt = 0; m_data = '0;
   endtask

   task automatic model_step();
      if (!reset) return;
      if (clear) begin
         m_active = 0; m_done = 0;
      end else if (m_done) begin
         m_done = 1;
      end else if (!m_active) begin
         if (success_bus != '0) begin
            m_core = lowest(success_bus); m_active = 1; m_byte = 0; m_cnt = 0;
         end
      end else if (m_cnt < 2) begin
         if (m_cnt == 1) m_data = mem[m_core][m_byte];
         m_cnt++;
      end else if (out_ready) begin
         if (m_byte == ML - 1) begin m_active = 0; m_done = 1; end
         else begin m_byte++; m_cnt = 0; end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      bit v;
      v = m_active && (m_cnt == 2);
      chk("busy", busy, m_active);
      chk("a_rd_en", a_rd_en, m_active);
      chk("out_valid", out_valid, v);
      chk("out_last", out_last, v && (m_byte == ML - 1));
      chk("done", done, m_done);
      chk("a_rd_addr", a_rd_addr, m_active ? m_byte : 0);
      chk("core_idx", core_idx, m_core);
      chk("out_data", out_data, m_data);
   endtask

   task automatic tick();
      if (reset && !clear && out_valid && out_ready) got_q.push_back(out_data);
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic async_reset();
      reset = 1'b0;
      model_reset();
      #1;
      compare_all();
   endtask

   task automatic pulse_clear();
      clear = 1'b1; tick(); clear = 1'b0;
   endtask

   task automatic run_to_done(input int budget, input bit rnd_ready);
      int n = 0;
      while (!m_done && n < budget) begin
         out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         tick(); n++;
      end
      out_ready = 1'b1;
      chk("run_to_done_bound", m_done, 1);
   endtask

   task automatic wait_hold(input int b, input int budget);
      int n = 0;
      while (!(m_active && m_cnt == 2 && m_byte == b) && n < budget) begin tick(); n++; end
      chk("wait_hold_bound", m_active && m_cnt == 2 && m_byte == b, 1);
   endtask

   task automatic check_stream(input int c);
      chk("stream_len", got_q.size(), ML);
      for (int i = 0; i < ML && i < got_q.size(); i++) chk("stream_byte", got_q[i], mem[c][i]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int c, e, last_cnt;
      logic [RW-1:0] held;
      logic [NC-1:0] s;
      for (int k = 0; k < NC; k++)
         for (int i = 0; i < ML; i++) mem[k][i] = RW'($urandom);
      for (int i = 0; i < ML; i++) mem[7][i] = RW'(8'h61 + i);

      // Reset state
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b1;
      tick();

      // Scenario 1: core 7, fixed latency and ordering
      got_q.delete();
      success_bus = '0; success_bus[7] = 1'b1;
      tick(); success_bus = '0;
      tick(); chk("s1_valid_edge1", out_valid, 0);
      tick(); chk("s1_valid_edge2", out_valid, 1);
      chk("s1_first_byte", out_data, 8'h61);
      chk("s1_core_idx", core_idx, 7);
      e = 2; last_cnt = 0;
      while (!m_done && e < 200) begin
         if (out_last) begin last_cnt++; chk("s1_last_data", out_data, 8'h80); end
         tick(); e++;
      end
      chk("s1_cycles", e, 3 * ML);
      chk("s1_last_count", last_cnt, 1);
      chk("s1_done", done, 1);
      check_stream(7);
      pulse_clear();
      chk("s1_clear_done", done, 0);

      // clear wins over success in IDLE
      clear = 1'b1; success_bus[9] = 1'b1;
      tick(); chk("clear_wins_busy", busy, 0);
      clear = 1'b0; success_bus = '0;
      tick();

      // Scenario 2: two simultaneous winners, random backpressure
      got_q.delete();
      success_bus[3] = 1'b1; success_bus[40] = 1'b1;
      tick(); success_bus = '0;
      chk("s2_core_idx", core_idx, 3);
      run_to_done(600, 1);
      check_stream(3);
      pulse_clear();

      // Scenario 3: stall on byte 10
      got_q.delete();
      c = $urandom_range(0, NC - 1);
      success_bus[c] = 1'b1; tick(); success_bus = '0;
      wait_hold(10, 100);
      held = out_data;
      chk("s3_held_byte", held, mem[c][10]);
      out_ready = 1'b0;
      repeat (5) begin
         tick();
         chk("s3_stable", out_data, held);
         chk("s3_addr", a_rd_addr, 10);
      end
      out_ready = 1'b1;
      run_to_done(300, 0);
      check_stream(c);
      pulse_clear();

      // Scenario 4: reset during byte 15, restart with core 2
      success_bus[20] = 1'b1; tick(); success_bus = '0;
      wait_hold(15, 100);
      async_reset();
      chk("s4_valid", out_valid, 0);
      chk("s4_addr", a_rd_addr, 0);
      chk("s4_core", core_idx, 0);
      chk("s4_data", out_data, 0);
      tick(); tick();
      reset = 1'b1;
      got_q.delete();
      success_bus[2] = 1'b1; tick(); success_bus = '0;
      chk("s4_restart_core", core_idx, 2);
      chk("s4_restart_addr", a_rd_addr, 0);
      run_to_done(300, 1);
      check_stream(2);
      pulse_clear();

      // Scenario 5: success held through DONE, then clear restarts
      c = $urandom_range(0, NC - 1);
      success_bus[c] = 1'b1;
      run_to_done(300, 0);
      repeat (4) tick();
      chk("s5_done_held", done, 1);
      chk("s5_no_restart", busy, 0);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("s5_done_cleared", done, 0);
      chk("s5_idle", busy, 0);
      got_q.delete();
      tick();
      chk("s5_restart_busy", busy, 1);
      chk("s5_restart_addr", a_rd_addr, 0);
      success_bus = '0;
      run_to_done(300, 1);
      check_stream(c);
      pulse_clear();

      // Scenario 6: clear during HOLD of byte 5
      c = $urandom_range(0, NC - 1);
      success_bus[c] = 1'b1; tick(); success_bus = '0;
      wait_hold(5, 100);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("s6_valid", out_valid, 0);
      chk("s6_busy", busy, 0);
      chk("s6_core_kept", core_idx, c);
      tick();

      // Randomized phase
      for (int cyc = 0; cyc < 3000; cyc++) begin
         s = '0;
         if ($urandom_range(0, 9) == 0)
            repeat ($urandom_range(1, 3)) s[$urandom_range(0, NC - 1)] = 1'b1;
         success_bus = s;
         out_ready = ($urandom_range(0, 2) != 0);
         clear = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 299) == 0) begin
            async_reset();
            reset = 1'b1;
         end
         tick();
      end
      success_bus = '0; clear = 1'b0; out_ready = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
